// File: rtl/lif_pkg.sv
// lif_pkg: shared constants and helpers for the LIF neuron chain.
// Coupling modes, saturating add and refractory counter sizing.
package lif_pkg;

  localparam int LIF_COUPLE_VMEM  = 0;
  localparam int LIF_COUPLE_SPIKE = 1;
  localparam int LIF_CNT_W        = 16;

  // a + b clamped to 2^w - 1 (w <= 32); callers size-cast the result
  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned w
  );
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return (s > m) ? m[31:0] : s[31:0];
  endfunction

  function automatic int refrac_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lif_if.sv
// lif_if: control/input and observation bundle of the neuron chain.
// master drives ena/i_syn, slave (the chain) drives the outputs.
interface lif_if #(
  parameter int N_STAGES = 7,
  parameter int WIDTH    = 8
);
  logic                ena;
  logic [WIDTH-1:0]    i_syn;
  logic [WIDTH-1:0]    v_mem_out;
  logic [N_STAGES-1:0] spike_out;
  logic [15:0]         spike_count;

  modport master (
    output ena,
    output i_syn,
    input  v_mem_out,
    input  spike_out,
    input  spike_count
  );

  modport slave (
    input  ena,
    input  i_syn,
    output v_mem_out,
    output spike_out,
    output spike_count
  );
endinterface

// File: rtl/lif_neuron_chain_stage.sv
// lif_stage: one leaky integrate-and-fire neuron.
// Holds membrane v, refractory counter r and the spike flag.
module lif_stage
  import lif_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int THRESHOLD     = 200,
  parameter int LEAK_SHIFT    = 1,
  parameter int REFRAC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] v_o,
  output logic             spike_o,
  output logic             fire_o
);

  localparam int RW = refrac_w(REFRAC_CYCLES);
  localparam logic [WIDTH-1:0] TH = WIDTH'(THRESHOLD);
  localparam logic [RW-1:0] RMAX = RW'(REFRAC_CYCLES);

  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] leaked;
  logic [RW-1:0]    r_q, r_d;
  logic             spike_q, spike_d;
  logic             refr;

  assign refr   = (r_q != '0);
  assign leaked = v_q - (v_q >> LEAK_SHIFT);
  assign fire_o = ena && !refr && (v_q >= TH);

  always_comb begin
    v_d     = v_q;
    r_d     = r_q;
    spike_d = spike_q;
    if (ena) begin
      if (refr) begin
        v_d     = '0;
        r_d     = r_q - RW'(1);
        spike_d = 1'b0;
      end else if (v_q >= TH) begin
        v_d     = '0;
        r_d     = RMAX;
        spike_d = 1'b1;
      end else begin
        v_d     = WIDTH'(sat_add(32'(leaked), 32'(in_i), WIDTH));
        spike_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      r_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      r_q     <= r_d;
      spike_q <= spike_d;
    end
  end

  assign v_o     = v_q;
  assign spike_o = spike_q;

endmodule

// File: rtl/lif_neuron_chain.sv
// lif_neuron_chain: N_STAGES cascaded LIF neurons with coupling mux.
// Optional last-stage spike counter behind macro LIF_SPIKE_COUNT_EN.
module lif_neuron_chain
  import lif_pkg::*;
#(
  parameter int N_STAGES      = 7,
  parameter int WIDTH         = 8,
  parameter int THRESHOLD     = 200,
  parameter int LEAK_SHIFT    = 1,
  parameter int REFRAC_CYCLES = 2,
  parameter int COUPLING_MODE = LIF_COUPLE_VMEM,
  parameter int SPIKE_WEIGHT  = 100
) (
  input  logic clk,
  input  logic rst_n,
  lif_if.slave bus
);

  localparam logic [WIDTH-1:0] SW = WIDTH'(SPIKE_WEIGHT);

  logic [N_STAGES-1:0][WIDTH-1:0] v;
  logic [N_STAGES-1:0][WIDTH-1:0] stage_in;
  logic [N_STAGES-1:0]            spike;
  logic [N_STAGES-1:0]            fire;
  logic                           unused_sig;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_src
      assign stage_in[k] = bus.i_syn;
    end else if (COUPLING_MODE == LIF_COUPLE_SPIKE) begin : g_spk
      assign stage_in[k] = spike[k-1] ? SW : '0;
    end else begin : g_vm
      assign stage_in[k] = v[k-1];
    end

    lif_stage #(
      .WIDTH        (WIDTH),
      .THRESHOLD    (THRESHOLD),
      .LEAK_SHIFT   (LEAK_SHIFT),
      .REFRAC_CYCLES(REFRAC_CYCLES)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (bus.ena),
      .in_i   (stage_in[k]),
      .v_o    (v[k]),
      .spike_o(spike[k]),
      .fire_o (fire[k])
    );
  end

  // inner membranes are dead in spike coupling, fire only feeds the counter
  assign unused_sig = ^{fire, v};

  assign bus.v_mem_out = v[N_STAGES-1];
  assign bus.spike_out = spike;

`ifdef LIF_SPIKE_COUNT_EN
  logic [LIF_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (fire[N_STAGES-1] && (cnt_q != '1)) begin
      cnt_d = cnt_q + LIF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.spike_count = cnt_q;
`else
  assign bus.spike_count = '0;
`endif

endmodule

// File: tb/tb_lif_neuron_chain.sv
// tb_lif_neuron_chain: directed table + hand sequences for the LIF chain.
// Four instances cover default, single-stage, saturation and spike coupling.
module tb_lif_neuron_chain;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef LIF_SPIKE_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  lif_if #(.N_STAGES(7), .WIDTH(8)) if_d ();
  lif_if #(.N_STAGES(1), .WIDTH(8)) if_c ();
  lif_if #(.N_STAGES(2), .WIDTH(8)) if_s ();
  lif_if #(.N_STAGES(3), .WIDTH(8)) if_m ();

  lif_neuron_chain #(.N_STAGES(7)) dut_d (
    .clk(clk), .rst_n(rst_n), .bus(if_d)
  );
  lif_neuron_chain #(.N_STAGES(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c)
  );
  lif_neuron_chain #(.N_STAGES(2), .THRESHOLD(255)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(if_s)
  );
  lif_neuron_chain #(
    .N_STAGES(3), .THRESHOLD(200),
    .COUPLING_MODE(1), .SPIKE_WEIGHT(200)
  ) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(if_m)
  );

  typedef struct {
    bit         rst;
    bit         ena;
    logic [7:0] syn;
    logic [7:0] v;
    bit         sp;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit e, input int syn,
                     input int v, input bit sp, input int cnt);
    vec_t row;
    row.rst = r;
    row.ena = e;
    row.syn = 8'(syn);
    row.v   = 8'(v);
    row.sp  = sp;
    row.cnt = 16'(cnt);
    vq.push_back(row);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle_all();
    if_d.ena = 1'b0; if_d.i_syn = '0;
    if_c.ena = 1'b0; if_c.i_syn = '0;
    if_s.ena = 1'b0; if_s.i_syn = '0;
    if_m.ena = 1'b0; if_m.i_syn = '0;
  endtask

  task automatic edge_chk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int va[24];
    va = '{100, 150, 175, 188, 194, 197, 199, 200, 0, 0, 0, 100,
           150, 175, 188, 194, 197, 199, 200, 0, 0, 0, 100, 150};

    // 24 cycles of i_syn=100: spikes at edges 9 and 20
    for (int i = 0; i < 24; i++) begin
      add(i == 0, 1'b1, 100, va[i], (i == 8) || (i == 19),
          (i < 8) ? 0 : (i < 19) ? 1 : 2);
    end
    // spike, then freeze with the flag high
    for (int i = 0; i < 9; i++) begin
      add(i == 0, 1'b1, 100, va[i], i == 8, (i == 8) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 255, 0, 1'b1, 1);
    add(1'b0, 1'b1, 100, 0, 1'b0, 1);
    // reset lands mid-refractory: next edge integrates again
    add(1'b1, 1'b1, 100, 100, 1'b0, 0);
    add(1'b0, 1'b1, 100, 150, 1'b0, 0);
    add(1'b0, 1'b1, 100, 175, 1'b0, 0);
    for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 255, 175, 1'b0, 0);
    add(1'b0, 1'b1, 100, 188, 1'b0, 0);

    // reset held with full input
    rst_n = 1'b0;
    if_d.ena = 1'b1; if_d.i_syn = 8'd255;
    if_c.ena = 1'b1; if_c.i_syn = 8'd255;
    if_s.ena = 1'b1; if_s.i_syn = 8'd255;
    if_m.ena = 1'b1; if_m.i_syn = 8'd255;
    repeat (3) @(posedge clk);
    #1;
    chk("rst d v", 32'(if_d.v_mem_out), 0);
    chk("rst d sp", 32'(if_d.spike_out), 0);
    chk("rst d cnt", 32'(if_d.spike_count), 0);
    chk("rst c v", 32'(if_c.v_mem_out), 0);
    chk("rst c sp", 32'(if_c.spike_out), 0);
    chk("rst c cnt", 32'(if_c.spike_count), 0);
    chk("rst s v", 32'(if_s.v_mem_out), 0);
    chk("rst s sp", 32'(if_s.spike_out), 0);
    chk("rst m v", 32'(if_m.v_mem_out), 0);
    chk("rst m sp", 32'(if_m.spike_out), 0);
    idle_all();
    #1 rst_n = 1'b1;

    // single-stage table
    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      if_c.ena   = vq[i].ena;
      if_c.i_syn = vq[i].syn;
      edge_chk();
      chk($sformatf("row%0d v", i), 32'(if_c.v_mem_out), 32'(vq[i].v));
      chk($sformatf("row%0d sp", i), 32'(if_c.spike_out), 32'(vq[i].sp));
      chk($sformatf("row%0d cnt", i), 32'(if_c.spike_count),
          CNT_ON ? 32'(vq[i].cnt) : 32'd0);
    end
    idle_all();

    // 7-stage mode-0 latency, then async reset between edges
    do_reset();
    if_d.ena = 1'b1; if_d.i_syn = 8'd100;
    for (int e = 1; e <= 8; e++) begin
      edge_chk();
      if (e == 3) chk("lat sp e3", 32'(if_d.spike_out), 0);
      if (e == 4) chk("lat sp e4", 32'(if_d.spike_out), 32'h02);
      if (e == 6) chk("lat v e6", 32'(if_d.v_mem_out), 0);
      if (e == 7) chk("lat v e7", 32'(if_d.v_mem_out), 100);
    end
    #3 rst_n = 1'b0;
    #1;
    chk("async v", 32'(if_d.v_mem_out), 0);
    chk("async sp", 32'(if_d.spike_out), 0);
    chk("async cnt", 32'(if_d.spike_count), 0);
    idle_all();
    #1 rst_n = 1'b1;

    // saturation in stage 0 and stage 1, TH=255
    do_reset();
    if_s.ena = 1'b1; if_s.i_syn = 8'd200;
    edge_chk();
    chk("sat v e1", 32'(if_s.v_mem_out), 0);
    edge_chk();
    chk("sat v e2", 32'(if_s.v_mem_out), 200);
    if_s.i_syn = 8'd255;
    edge_chk();
    chk("sat v e3", 32'(if_s.v_mem_out), 255);
    chk("sat sp e3", 32'(if_s.spike_out), 32'h1);
    edge_chk();
    chk("sat v e4", 32'(if_s.v_mem_out), 0);
    chk("sat sp e4", 32'(if_s.spike_out), 32'h2);
    idle_all();

    // spike coupling: stage 0 spike at edge 2 walks down the chain
    do_reset();
    if_m.ena = 1'b1; if_m.i_syn = 8'd200;
    edge_chk();
    chk("m sp e1", 32'(if_m.spike_out), 0);
    if_m.i_syn = 8'd0;
    edge_chk();
    chk("m sp e2", 32'(if_m.spike_out), 32'h1);
    edge_chk();
    chk("m sp e3", 32'(if_m.spike_out), 0);
    edge_chk();
    chk("m sp e4", 32'(if_m.spike_out), 32'h2);
    edge_chk();
    chk("m sp e5", 32'(if_m.spike_out), 0);
    chk("m v e5", 32'(if_m.v_mem_out), 200);
    edge_chk();
    chk("m sp e6", 32'(if_m.spike_out), 32'h4);
    chk("m v e6", 32'(if_m.v_mem_out), 0);
    idle_all();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
